// File: rtl/game_flow_ctrl_pkg.sv
// Shared game-state definitions for the flow controller, the stage timer, the display and the scene logic.
package game_flow_ctrl_pkg;

  localparam int STATE_W = 4;

  // Encoding is fixed: downstream blocks decode these raw values.
  typedef enum logic [STATE_W-1:0] {
    TITLE    = 4'd0,
    STAFF    = 4'd1,
    STAGE1   = 4'd2,
    SUCCESS1 = 4'd3,
    STAGE2   = 4'd4,
    SUCCESS2 = 4'd5,
    STAGE3   = 4'd6,
    SUCCESS3 = 4'd7,
    FAIL     = 4'd8
  } game_state_e;

  // True for the three playable stage states.
  function automatic logic is_stage(input game_state_e s);
    return (s == STAGE1) || (s == STAGE2) || (s == STAGE3);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_screen_hold_cnt.sv
// Saturating dwell counter for the intermediate success screens.
// Cleared while 'clear' is high; counts while 'en' is high; stops at HOLD_CYCLES-1.
// 'done' depends only on the count register, so it can feed next-state logic without a combinational loop.
module screen_hold_cnt #(
  parameter int HOLD_CYCLES = 200000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count up while enabled, saturating at the terminal value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == CNT_MAX);

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: title/staff screens, three timed stages with lives, success and fail screens.
// All outputs are registered; a transition appears on 'state' the cycle after its trigger.
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int          HOLD_CYCLES = 200000000,
  parameter int          LIVES_INIT  = 3,
  parameter logic [15:0] TIME_LIMIT  = 16'h0300
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_staff,
  input  logic               stage_clear,
  input  logic               player_hit,
  input  logic [15:0]        time_nums,
  output logic [STATE_W-1:0] state,
  output logic [1:0]         lives,
  output logic               stage_start
);

  localparam logic [1:0] LIVES_RELOAD = 2'(LIVES_INIT);

  game_state_e state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic        stage_start_q, stage_start_d;
  logic        in_hold;
  logic        hold_done;
  logic        time_up;

  // Packed BCD orders the same as binary, so a plain unsigned compare works.
  assign time_up = (time_nums >= TIME_LIMIT);
  assign in_hold = (state_q == SUCCESS1) || (state_q == SUCCESS2);

  screen_hold_cnt #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clear(~in_hold),
    .en   (in_hold),
    .done (hold_done)
  );

  // Next-state, lives and stage-entry pulse decode.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    case (state_q)
      TITLE: begin
        if (btn_start)      state_d = STAGE1;
        else if (btn_staff) state_d = STAFF;
      end
      STAFF: begin
        if (btn_start) state_d = TITLE;
      end
      STAGE1, STAGE2, STAGE3: begin
        // Clearing the stage outranks both timeout and damage in the same cycle.
        if (stage_clear) begin
          state_d = (state_q == STAGE1) ? SUCCESS1 :
                    (state_q == STAGE2) ? SUCCESS2 : SUCCESS3;
        end else if (time_up) begin
          state_d = FAIL;
        end else if (player_hit) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = FAIL;
          end else begin
            lives_d = lives_q - 2'd1;
          end
        end
      end
      SUCCESS1, SUCCESS2: begin
        if (btn_start || hold_done) begin
          state_d = (state_q == SUCCESS1) ? STAGE2 : STAGE3;
        end
      end
      SUCCESS3, FAIL: begin
        if (btn_start) state_d = TITLE;
      end
      default: state_d = TITLE;
    endcase
    // Lives are refilled while sitting in TITLE and on the way into it.
    if ((state_q == TITLE) || (state_d == TITLE)) lives_d = LIVES_RELOAD;
    stage_start_d = is_stage(state_d) && (state_d != state_q);
  end

  // State, lives and pulse registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= TITLE;
      lives_q       <= LIVES_RELOAD;
      stage_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      stage_start_q <= stage_start_d;
    end
  end

  assign state       = state_q;
  assign lives       = lives_q;
  assign stage_start = stage_start_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios followed by randomized play, checked every cycle
// against a screen/level model of the game rules.
module tb_game_flow_ctrl;

  localparam int          HOLD        = 10;
  localparam int          LIVES_INIT  = 3;
  localparam logic [15:0] LIMIT       = 16'h0300;

  // Model screen kinds (independent of the DUT encoding).
  localparam int K_TITLE   = 0;
  localparam int K_STAFF   = 1;
  localparam int K_STAGE   = 2;
  localparam int K_SUCCESS = 3;
  localparam int K_FAIL    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_staff = 1'b0;
  logic        stage_clear = 1'b0;
  logic        player_hit = 1'b0;
  logic [15:0] time_nums = 16'h0000;
  logic [3:0]  state;
  logic [1:0]  lives;
  logic        stage_start;

  int tests = 0;
  int fails = 0;

  // Model state
  int m_kind  = K_TITLE;
  int m_level = 1;
  int m_lives = LIVES_INIT;
  int m_hold  = 0;
  int m_ss    = 0;

  game_flow_ctrl #(
    .HOLD_CYCLES(HOLD),
    .LIVES_INIT (LIVES_INIT),
    .TIME_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start  (btn_start),
    .btn_staff  (btn_staff),
    .stage_clear(stage_clear),
    .player_hit (player_hit),
    .time_nums  (time_nums),
    .state      (state),
    .lives      (lives),
    .stage_start(stage_start)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [3:0] model_code();
    case (m_kind)
      K_TITLE:   return 4'd0;
      K_STAFF:   return 4'd1;
      K_STAGE:   return 4'(2 * m_level);
      K_SUCCESS: return 4'(2 * m_level + 1);
      default:   return 4'd8;
    endcase
  endfunction

  // Apply one clock's worth of inputs to the game rules.
  task automatic model_step(input logic r, s, f, c, h, input logic [15:0] t);
    int old_kind;
    old_kind = m_kind;
    if (r) begin
      m_kind = K_TITLE; m_lives = LIVES_INIT; m_hold = 0; m_ss = 0;
      return;
    end
    case (m_kind)
      K_TITLE: begin
        m_lives = LIVES_INIT;
        if (s) begin m_kind = K_STAGE; m_level = 1; end
        else if (f) m_kind = K_STAFF;
      end
      K_STAFF: if (s) m_kind = K_TITLE;
      K_STAGE: begin
        if (c) begin m_kind = K_SUCCESS; m_hold = 0; end
        else if (t >= LIMIT) m_kind = K_FAIL;
        else if (h) begin
          if (m_lives == 1) begin m_lives = 0; m_kind = K_FAIL; end
          else m_lives = m_lives - 1;
        end
      end
      K_SUCCESS: begin
        if (m_level == 3) begin
          if (s) m_kind = K_TITLE;
        end else if (s || m_hold == HOLD - 1) begin
          m_kind = K_STAGE; m_level = m_level + 1;
        end else begin
          m_hold = m_hold + 1;
        end
      end
      default: if (s) m_kind = K_TITLE;
    endcase
    if (m_kind == K_TITLE) m_lives = LIVES_INIT;
    m_ss = (m_kind == K_STAGE && old_kind != K_STAGE) ? 1 : 0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare all outputs.
  task automatic cyc(input logic r, s, f, c, h, input logic [15:0] t);
    @(negedge clk);
    rst = r; btn_start = s; btn_staff = f; stage_clear = c; player_hit = h; time_nums = t;
    model_step(r, s, f, c, h, t);
    @(posedge clk);
    #1;
    chk("state", 16'(state), 16'(model_code()));
    chk("lives", 16'(lives), 16'(m_lives));
    chk("stage_start", 16'(stage_start), 16'(m_ss));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 16'h0000);
  endtask

  task automatic press_start();
    cyc(0, 1, 0, 0, 0, 16'h0000);
  endtask

  initial begin
    // Reset and quiet period
    cyc(1, 0, 0, 0, 0, 16'h0000);
    cyc(1, 1, 1, 1, 1, 16'h0400);
    chk("reset_state", 16'(state), 16'd0);
    chk("reset_lives", 16'(lives), 16'd3);
    idle(20);

    // Simultaneous start and staff: start wins
    cyc(0, 1, 1, 0, 0, 16'h0000);
    chk("dual_press_state", 16'(state), 16'd2);
    chk("dual_press_pulse", 16'(stage_start), 16'd1);
    idle(1);
    chk("pulse_one_cycle", 16'(stage_start), 16'd0);

    // Back to title, staff screen round trip
    cyc(1, 0, 0, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, 0, 16'h0000);
    chk("staff_open", 16'(state), 16'd1);
    cyc(0, 0, 1, 0, 0, 16'h0000);
    press_start();
    chk("staff_close", 16'(state), 16'd0);

    // Stage clear, auto-advance after the dwell, then early skip in SUCCESS2
    press_start();
    cyc(0, 0, 0, 1, 0, 16'h0000);
    chk("clear1", 16'(state), 16'd3);
    idle(HOLD);
    chk("auto_advance", 16'(state), 16'd4);
    chk("auto_advance_pulse", 16'(stage_start), 16'd1);
    cyc(0, 0, 0, 1, 0, 16'h0000);
    idle(1);
    press_start();
    chk("skip_hold", 16'(state), 16'd6);

    // Clear and hit together in STAGE3: clear wins, lives kept
    cyc(0, 0, 0, 1, 1, 16'h0000);
    chk("clear_hit_state", 16'(state), 16'd7);
    chk("clear_hit_lives", 16'(lives), 16'd3);
    idle(50);
    chk("success3_terminal", 16'(state), 16'd7);
    press_start();
    chk("success3_exit", 16'(state), 16'd0);

    // Three hits drain lives into FAIL
    press_start();
    for (int k = 0; k < 3; k++) begin
      idle(4);
      cyc(0, 0, 0, 0, 1, 16'h0000);
    end
    chk("hits_fail_state", 16'(state), 16'd8);
    chk("hits_fail_lives", 16'(lives), 16'd0);
    press_start();
    chk("fail_exit_lives", 16'(lives), 16'd3);

    // Time limit in STAGE2
    press_start();
    cyc(0, 0, 0, 1, 0, 16'h0000);
    press_start();
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 16'h0259);
    chk("below_limit", 16'(state), 16'd4);
    cyc(0, 0, 0, 0, 0, 16'h0300);
    chk("time_up", 16'(state), 16'd8);
    press_start();

    // Reset mid-STAGE2 after a hit
    press_start();
    cyc(0, 0, 0, 1, 0, 16'h0000);
    press_start();
    cyc(0, 0, 0, 0, 1, 16'h0100);
    cyc(1, 0, 0, 0, 0, 16'h0100);
    chk("mid_reset_state", 16'(state), 16'd0);
    chk("mid_reset_lives", 16'(lives), 16'd3);

    // Randomized play
    for (int n = 0; n < 4000; n++) begin
      logic r, s, f, c, h;
      logic [15:0] t;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 11) == 0);
      h = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 24) == 0) t = LIMIT + 16'($urandom_range(0, 3));
      else t = 16'($urandom_range(0, 16'h02FF));
      cyc(r, s, f, c, h, t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
